// File: rtl/pipeline_pkg.sv
// +----------------------------------------------------------------------------+
// | pipeline_pkg : shared control-field types and FSM encoding for MEM stage   |
// | Revision     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

    localparam int MEM_CTRL_W = 2;
    localparam int WB_CTRL_W  = 2;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mau_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | mem_access_unit : MEM-stage controller, issues data-memory accesses and    |
// |                   stalls upstream while one is outstanding                 |
// | Revision        : 1.0 - initial release                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int REG_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   alu_res_in,
    input  logic [DATA_WIDTH-1:0]   write_data_in,
    input  logic [MEM_CTRL_W-1:0]   mem_control_in,
    input  logic [WB_CTRL_W-1:0]    wb_control_in,
    input  logic [REG_ID_WIDTH-1:0] dest_in,
    output logic                    stall,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic                    dmem_req_write,
    output logic [DATA_WIDTH-1:0]   dmem_req_addr,
    output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
    input  logic                    dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   dmem_resp_data,
    output logic                    valid_out,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    output logic [DATA_WIDTH-1:0]   alu_res_out,
    output logic [REG_ID_WIDTH-1:0] dest_out,
    output logic [WB_CTRL_W-1:0]    wb_control_out,
    output logic                    ctrl_err
);

    mau_state_t              r_state;
    mau_state_t              w_state_next;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_write;
    logic [REG_ID_WIDTH-1:0] r_dest;
    logic [WB_CTRL_W-1:0]    r_wb;

    mem_ctrl_t               w_mc;
    logic                    w_is_mem;
    logic                    w_finish;

    assign w_mc     = mem_ctrl_t'(mem_control_in);
    assign w_is_mem = valid_in && (w_mc.mem_read ^ w_mc.mem_write);

    assign dmem_req_valid = (r_state == REQ);
    assign dmem_req_write = r_write;
    assign dmem_req_addr  = r_addr;
    assign dmem_req_wdata = r_wdata;

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                stall = w_is_mem;
                if (w_is_mem) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                // A response coincident with the handshake completes the access at once
                stall = !(dmem_req_ready && dmem_resp_valid);
                if (dmem_req_ready) begin
                    w_finish     = dmem_resp_valid;
                    w_state_next = dmem_resp_valid ? IDLE : WAIT;
                end
            end
            WAIT: begin
                stall    = !dmem_resp_valid;
                w_finish = dmem_resp_valid;
                if (dmem_resp_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_write        <= 1'b0;
            r_dest         <= '0;
            r_wb           <= '0;
            valid_out      <= 1'b0;
            mem_data_out   <= '0;
            alu_res_out    <= '0;
            dest_out       <= '0;
            wb_control_out <= '0;
            ctrl_err       <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            valid_out <= 1'b0;
            ctrl_err  <= 1'b0;
            if (r_state == IDLE && valid_in) begin
                if (w_is_mem) begin
                    r_addr  <= alu_res_in;
                    r_wdata <= write_data_in;
                    r_write <= w_mc.mem_write;
                    r_dest  <= dest_in;
                    r_wb    <= wb_control_in;
                end else begin
                    // Covers both plain ALU ops and the illegal read+write encoding
                    valid_out      <= 1'b1;
                    alu_res_out    <= alu_res_in;
                    dest_out       <= dest_in;
                    wb_control_out <= wb_control_in;
                    mem_data_out   <= '0;
                    ctrl_err       <= w_mc.mem_read && w_mc.mem_write;
                end
            end
            if (w_finish) begin
                valid_out      <= 1'b1;
                alu_res_out    <= r_addr;
                dest_out       <= r_dest;
                wb_control_out <= r_wb;
                mem_data_out   <= r_write ? '0 : dmem_resp_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit : scoreboard bench with randomized upstream and memory  |
// | Revision           : 1.0 - initial release                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

    localparam int DW = 64;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] alu_res_in;
    logic [DW-1:0] write_data_in;
    logic [1:0]    mem_control_in;
    logic [1:0]    wb_control_in;
    logic [RW-1:0] dest_in;
    logic          stall;
    logic          dmem_req_valid;
    logic          dmem_req_ready;
    logic          dmem_req_write;
    logic [DW-1:0] dmem_req_addr;
    logic [DW-1:0] dmem_req_wdata;
    logic          dmem_resp_valid;
    logic [DW-1:0] dmem_resp_data;
    logic          valid_out;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] alu_res_out;
    logic [RW-1:0] dest_out;
    logic [1:0]    wb_control_out;
    logic          ctrl_err;

    mem_access_unit #(.DATA_WIDTH(DW), .REG_ID_WIDTH(RW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_res_in(alu_res_in),
        .write_data_in(write_data_in), .mem_control_in(mem_control_in),
        .wb_control_in(wb_control_in), .dest_in(dest_in), .stall(stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_write(dmem_req_write), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data(dmem_resp_data), .valid_out(valid_out),
        .mem_data_out(mem_data_out), .alu_res_out(alu_res_out),
        .dest_out(dest_out), .wb_control_out(wb_control_out), .ctrl_err(ctrl_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] alu;
        logic [RW-1:0] dest;
        logic [1:0]    wb;
        logic          is_mem;
        logic          err;
    } exp_t;

    typedef struct {
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          write;
    } req_t;

    exp_t          exp_q[$];
    req_t          req_q[$];
    logic [DW-1:0] resp_q[$];

    int checks   = 0;
    int failures = 0;

    // Memory-model knobs: negative values mean randomized behaviour
    int            force_hold  = -1;
    int            force_delay = -1;
    logic          force_data_en = 1'b0;
    logic [DW-1:0] force_data  = '0;
    logic          hold_resp   = 1'b0;
    logic          inject_stray = 1'b0;
    logic          mon_en      = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Upstream stage: holds an instruction until it sees stall low at a clock edge
    task automatic issue(input logic v, input logic [1:0] mc, input logic [DW-1:0] alu,
                         input logic [DW-1:0] wd, input logic [RW-1:0] dst,
                         input logic [1:0] wb, output int stall_cycles);
        exp_t e;
        req_t r;
        logic st;
        logic single;
        int   guard;
        single       = (mc == 2'b01) || (mc == 2'b10);
        guard        = 0;
        stall_cycles = 0;
        @(negedge clk);
        valid_in       = v;
        mem_control_in = mc;
        alu_res_in     = alu;
        write_data_in  = wd;
        dest_in        = dst;
        wb_control_in  = wb;
        if (v) begin
            e.alu = alu; e.dest = dst; e.wb = wb; e.is_mem = single; e.err = (mc == 2'b11);
            exp_q.push_back(e);
            if (single) begin
                r.addr = alu; r.wdata = wd; r.write = mc[0];
                req_q.push_back(r);
            end
        end
        forever begin
            #2;
            st = stall;
            if (guard == 0) chk("stall_on_issue", {63'd0, st}, {63'd0, v && single});
            if (st) stall_cycles++;
            @(posedge clk);
            if (!st) break;
            guard++;
            if (guard > 60) begin
                chk("stall_timeout", 64'd1, 64'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Data-memory model
    initial begin : responder
        logic          pending;
        logic          pend_write;
        int            cnt;
        int            wait_cnt;
        int            delay;
        logic          rdy;
        logic [DW-1:0] data;
        pending  = 1'b0;
        cnt      = 0;
        wait_cnt = 0;
        pend_write = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = '0;
        forever begin
            @(negedge clk);
            dmem_resp_valid = 1'b0;
            dmem_req_ready  = 1'($urandom % 2);
            if (!reset) begin
                pending  = 1'b0;
                wait_cnt = 0;
            end else if (inject_stray) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (pending) begin
                if (!hold_resp) begin
                    if (cnt == 0) begin
                        data = force_data_en ? force_data : {$urandom, $urandom};
                        dmem_resp_valid = 1'b1;
                        dmem_resp_data  = data;
                        resp_q.push_back(pend_write ? '0 : data);
                        pending = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end else if (dmem_req_valid) begin
                rdy = (force_hold >= 0) ? (wait_cnt >= force_hold) : ($urandom % 3 != 0);
                dmem_req_ready = rdy;
                wait_cnt++;
                if (rdy) begin
                    wait_cnt   = 0;
                    pend_write = dmem_req_write;
                    delay      = (force_delay >= 0) ? force_delay : int'($urandom % 4);
                    if (delay == 0 && !hold_resp) begin
                        data = force_data_en ? force_data : {$urandom, $urandom};
                        dmem_resp_valid = 1'b1;
                        dmem_resp_data  = data;
                        resp_q.push_back(pend_write ? '0 : data);
                    end else begin
                        pending = 1'b1;
                        cnt     = (delay == 0) ? 0 : delay - 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset && dmem_req_valid && dmem_req_ready && req_q.size() > 0)
            void'(req_q.pop_front());
    end

    // Monitor: compares every presented result and request against the scoreboard
    initial begin : monitor
        exp_t          e;
        logic [DW-1:0] md;
        logic [DW-1:0] last_alu;
        last_alu = '0;
        forever begin
            @(negedge clk);
            if (!reset) last_alu = '0;
            if (mon_en) begin
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid_out", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        md = '0;
                        if (e.is_mem) begin
                            if (resp_q.size() == 0) chk("resp_missing", 64'd1, 64'd0);
                            else md = resp_q.pop_front();
                        end
                        chk("alu_res_out", alu_res_out, e.alu);
                        chk("dest_out", {59'd0, dest_out}, {59'd0, e.dest});
                        chk("wb_control_out", {62'd0, wb_control_out}, {62'd0, e.wb});
                        chk("mem_data_out", mem_data_out, md);
                        chk("ctrl_err", {63'd0, ctrl_err}, {63'd0, e.err});
                        last_alu = e.alu;
                    end
                end else begin
                    chk("ctrl_err_idle", {63'd0, ctrl_err}, 64'd0);
                    chk("alu_res_hold", alu_res_out, last_alu);
                end
                if (dmem_req_valid) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 64'd1, 64'd0);
                    end else begin
                        chk("req_addr", dmem_req_addr, req_q[0].addr);
                        chk("req_wdata", dmem_req_wdata, req_q[0].wdata);
                        chk("req_write", {63'd0, dmem_req_write}, {63'd0, req_q[0].write});
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid_out"}, {63'd0, valid_out}, 64'd0);
        chk({tag, "_mem_data"}, mem_data_out, 64'd0);
        chk({tag, "_alu_res"}, alu_res_out, 64'd0);
        chk({tag, "_dest"}, {59'd0, dest_out}, 64'd0);
        chk({tag, "_wb"}, {62'd0, wb_control_out}, 64'd0);
        chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
        chk({tag, "_req_valid"}, {63'd0, dmem_req_valid}, 64'd0);
        chk({tag, "_req_write"}, {63'd0, dmem_req_write}, 64'd0);
        chk({tag, "_req_addr"}, dmem_req_addr, 64'd0);
        chk({tag, "_req_wdata"}, dmem_req_wdata, 64'd0);
        chk({tag, "_ctrl_err"}, {63'd0, ctrl_err}, 64'd0);
    endtask

    initial begin : stimulus
        int sc;
        int guard;
        logic [1:0] mc;
        reset = 1'b0;
        valid_in = 1'b0; alu_res_in = '0; write_data_in = '0;
        mem_control_in = '0; wb_control_in = '0; dest_in = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        mon_en = 1'b1;

        issue(1'b1, 2'b00, 64'h10, 64'h0, 5'd3, 2'b10, sc);
        chk("alu_stall_cycles", 64'(sc), 64'd0);

        force_hold = 0; force_delay = 2; force_data_en = 1'b1; force_data = 64'hDEADBEEF;
        issue(1'b1, 2'b10, 64'h100, 64'h0, 5'd7, 2'b11, sc);
        chk("load_stall_cycles", 64'(sc), 64'd3);

        force_hold = 3; force_delay = 1; force_data_en = 1'b0;
        issue(1'b1, 2'b01, 64'h200, 64'hAB, 5'd9, 2'b00, sc);
        chk("store_stall_cycles", 64'(sc), 64'd5);

        force_hold = 0; force_delay = 0;
        issue(1'b1, 2'b10, 64'h300, 64'h0, 5'd12, 2'b11, sc);
        chk("same_cycle_stall_cycles", 64'(sc), 64'd1);

        issue(1'b1, 2'b11, 64'h400, 64'h55, 5'd4, 2'b10, sc);
        chk("rw_both_stall_cycles", 64'(sc), 64'd0);
        issue(1'b0, 2'b10, 64'h500, 64'h0, 5'd1, 2'b00, sc);

        force_hold = -1; force_delay = -1;
        for (int i = 0; i < 250; i++) begin
            mc = 2'($urandom % 4);
            issue(($urandom % 5) != 0, mc, {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom), 2'($urandom), sc);
        end

        @(negedge clk);
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Abandon a load in WAIT via reset, then offer a stray response
        force_hold = 0; force_delay = 3; hold_resp = 1'b1;
        valid_in = 1'b1; mem_control_in = 2'b10; alu_res_in = 64'h600;
        dest_in = 5'd5; wb_control_in = 2'b11; write_data_in = '0;
        exp_q.push_back('{alu: 64'h600, dest: 5'd5, wb: 2'b11, is_mem: 1'b1, err: 1'b0});
        req_q.push_back('{addr: 64'h600, wdata: 64'h0, write: 1'b0});
        @(negedge clk);
        valid_in = 1'b0;
        guard = 0;
        while (dmem_req_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk("wait_stall_held", {63'd0, stall}, 64'd1);
        mon_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        exp_q.delete(); req_q.delete(); resp_q.delete();
        reset = 1'b1;
        hold_resp = 1'b0;
        inject_stray = 1'b1;
        @(negedge clk);
        inject_stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stray_valid_out", {63'd0, valid_out}, 64'd0);
            chk("stray_stall", {63'd0, stall}, 64'd0);
            @(negedge clk);
        end
        mon_en = 1'b1;
        force_hold = -1; force_delay = -1;
        issue(1'b1, 2'b00, 64'h77, 64'h0, 5'd2, 2'b10, sc);
        issue(1'b1, 2'b10, 64'h88, 64'h0, 5'd6, 2'b11, sc);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
